ps2_key_decoder: RTL

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver with glitch filter, frame check and make/break decoding
// for six tracked keys (D, A, E, Q, W, S); exposes both FSM states for observation.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILTER_LEN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [5:0] key_held,
    output logic       key_pressed,
    output logic       key_released,
    output logic       frame_err,
    output logic [1:0] o_dbg_rx_state,
    output logic [1:0] o_dbg_dec_state
);
    localparam int              FW   = $clog2(FILTER_LEN) + 1;
    localparam logic [FW-1:0]   FLIM = FW'(FILTER_LEN - 1);
    localparam logic [15:0]     TO   = 16'(TIMEOUT_CYC);

    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_SHIFT = 2'd1, RX_CHECK = 2'd2} rx_state_t;
    typedef enum logic [1:0] {DEC_BASE = 2'd0, DEC_BRK = 2'd1, DEC_EXT = 2'd2, DEC_EXT_BRK = 2'd3} dec_state_t;

    logic [1:0]    r_clk_sync, r_data_sync;
    logic          r_filt;
    logic [FW-1:0] r_filt_cnt;
    logic [15:0]   r_idle_cnt;
    rx_state_t     r_rx_state, w_rx_next;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic          r_byte_valid;
    logic [7:0]    r_byte;
    logic          r_frame_err;
    dec_state_t    r_dec_state, w_dec_next;
    logic [5:0]    r_held, w_held_next, w_key;
    logic          r_pressed, r_released, w_press, w_rel;
    logic          w_clk_s, w_data_s, w_filt_accept, w_fall, w_timeout;
    logic          w_byte_ok, w_rx_err;

    assign w_clk_s  = r_clk_sync[1];
    assign w_data_s = r_data_sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    // A new level is taken on the FILTER_LEN-th consecutive differing sample.
    assign w_filt_accept = (w_clk_s != r_filt) && (r_filt_cnt == FLIM);
    assign w_fall        = w_filt_accept && !w_clk_s;
    assign w_timeout     = (r_idle_cnt >= TO) && !w_filt_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_clk_s == r_filt) begin
                r_filt_cnt <= '0;
            end else if (w_filt_accept) begin
                r_filt     <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
            if (w_filt_accept)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != 16'hFFFF)
                r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    always_comb begin
        w_rx_next = r_rx_state;
        w_byte_ok = 1'b0;
        w_rx_err  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (w_fall && !w_data_s) w_rx_next = RX_SHIFT;
            RX_SHIFT: begin
                if (w_fall && r_bit_cnt == 4'd9) begin
                    w_rx_next = RX_CHECK;
                end else if (w_timeout) begin
                    w_rx_next = RX_IDLE;
                    w_rx_err  = 1'b1;
                end
            end
            RX_CHECK: begin
                w_rx_next = RX_IDLE;
                // r_shift holds {stop, parity, data[7:0]}.
                if ((^r_shift[8:0]) && r_shift[9]) w_byte_ok = 1'b1;
                else                                w_rx_err  = 1'b1;
            end
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state   <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == RX_SHIFT && w_fall) begin
                r_shift   <= {w_data_s, r_shift[9:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (r_rx_state == RX_IDLE) begin
                r_bit_cnt <= '0;
            end
            r_byte_valid <= w_byte_ok;
            r_byte       <= r_shift[7:0];
            r_frame_err  <= w_rx_err;
        end
    end

    always_comb begin
        case (r_byte)
            8'h23:   w_key = 6'b000001;
            8'h1C:   w_key = 6'b000010;
            8'h24:   w_key = 6'b000100;
            8'h15:   w_key = 6'b001000;
            8'h1D:   w_key = 6'b010000;
            8'h1B:   w_key = 6'b100000;
            default: w_key = 6'b000000;
        endcase
    end

    always_comb begin
        w_dec_next  = r_dec_state;
        w_held_next = r_held;
        w_press     = 1'b0;
        w_rel       = 1'b0;
        if (r_byte_valid) begin
            case (r_dec_state)
                DEC_BASE: begin
                    if (r_byte == 8'hF0) begin
                        w_dec_next = DEC_BRK;
                    end else if (r_byte == 8'hE0) begin
                        w_dec_next = DEC_EXT;
                    end else if (|w_key) begin
                        w_press     = ~|(r_held & w_key);
                        w_held_next = r_held | w_key;
                    end
                end
                DEC_BRK: begin
                    w_dec_next  = DEC_BASE;
                    w_rel       = |(r_held & w_key);
                    w_held_next = r_held & ~w_key;
                end
                // Extended codes are consumed without touching tracked keys.
                DEC_EXT:     w_dec_next = (r_byte == 8'hF0) ? DEC_EXT_BRK : DEC_BASE;
                DEC_EXT_BRK: w_dec_next = DEC_BASE;
                default:     w_dec_next = DEC_BASE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dec_state <= DEC_BASE;
            r_held      <= '0;
            r_pressed   <= 1'b0;
            r_released  <= 1'b0;
        end else begin
            r_dec_state <= w_dec_next;
            r_held      <= w_held_next;
            r_pressed   <= w_press;
            r_released  <= w_rel;
        end
    end

    assign key_held        = r_held;
    assign key_pressed     = r_pressed;
    assign key_released    = r_released;
    assign frame_err       = r_frame_err;
    assign o_dbg_rx_state  = r_rx_state;
    assign o_dbg_dec_state = r_dec_state;
endmodule
